// File: rtl/match_scheduler.sv
// match_scheduler: sequences games of a match, collecting player moves, issuing them to the game
// datapath and keeping score until a target win count or the game limit is reached.
module match_scheduler #(
    parameter int MAX_GAMES   = 7,
    parameter int RES_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       match_start,
    input  logic [1:0] target_wins,
    input  logic [3:0] rounds_cfg,
    input  logic [1:0] p1_move,
    input  logic [1:0] p2_move,
    input  logic       p1_valid,
    input  logic       p2_valid,
    output logic       p1_ready,
    output logic       p2_ready,
    output logic       game_start,
    output logic [1:0] game_p1,
    output logic [1:0] game_p2,
    input  logic [1:0] game_round,
    input  logic [1:0] game_result,
    output logic [1:0] score1,
    output logic [1:0] score2,
    output logic [3:0] games_played,
    output logic [1:0] match_winner,
    output logic       match_done,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOAD, COLLECT, ISSUE, WAIT, SCORE, DONE} state_t;

    localparam logic [3:0] TMO_LAST = 4'(RES_TIMEOUT - 1);
    localparam logic [3:0] GAME_MAX = 4'(MAX_GAMES);

    state_t     state_q, state_d;
    logic [1:0] tgt_q, tgt_d, m1_q, m1_d, m2_q, m2_d, res_q, res_d;
    logic [1:0] s1_q, s1_d, s2_q, s2_d, win_q, win_d;
    logic [3:0] cfg_q, cfg_d, tmo_q, tmo_d, gp_q, gp_d;
    logic       game_start_q, game_start_d;
    logic       cap1, cap2;

    // a held move is never 00, so a zero register doubles as "not yet captured"
    assign p1_ready     = state_q == COLLECT && m1_q == 2'b00;
    assign p2_ready     = state_q == COLLECT && m2_q == 2'b00;
    assign cap1         = p1_ready && p1_valid && p1_move != 2'b00;
    assign cap2         = p2_ready && p2_valid && p2_move != 2'b00;
    assign game_p1      = state_q == LOAD ? cfg_q[3:2] : state_q == ISSUE ? m1_q : 2'b00;
    assign game_p2      = state_q == LOAD ? cfg_q[1:0] : state_q == ISSUE ? m2_q : 2'b00;
    assign game_start   = game_start_q;
    assign score1       = s1_q;
    assign score2       = s2_q;
    assign games_played = gp_q;
    assign match_winner = win_q;
    assign match_done   = state_q == DONE;
    assign busy         = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cfg_d   = cfg_q;
        m1_d    = cap1 ? p1_move : m1_q;
        m2_d    = cap2 ? p2_move : m2_q;
        res_d   = res_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        gp_d    = gp_q;
        win_d   = win_q;
        tmo_d   = 4'd0;
        case (state_q)
            IDLE: if (match_start) begin
                tgt_d   = target_wins == 2'd0 ? 2'd1 : target_wins;
                cfg_d   = rounds_cfg;
                s1_d    = 2'd0;
                s2_d    = 2'd0;
                gp_d    = 4'd0;
                win_d   = 2'd0;
                state_d = LOAD;
            end
            LOAD:    state_d = COLLECT;
            COLLECT: if ((m1_q != 2'b00 || cap1) && (m2_q != 2'b00 || cap2)) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                tmo_d = tmo_q + 4'd1;
                m1_d  = 2'b00;
                m2_d  = 2'b00;
                if (game_result != 2'b00) begin
                    res_d   = game_result;
                    state_d = SCORE;
                end else if (game_round != 2'b00 || tmo_q == TMO_LAST) begin
                    state_d = COLLECT;
                end
            end
            SCORE: begin
                s1_d = res_q == 2'b01 && s1_q != 2'd3 ? s1_q + 2'd1 : s1_q;
                s2_d = res_q == 2'b10 && s2_q != 2'd3 ? s2_q + 2'd1 : s2_q;
                gp_d = gp_q != 4'd15 ? gp_q + 4'd1 : gp_q;
                if (s1_d == tgt_q || s2_d == tgt_q || gp_d == GAME_MAX) begin
                    win_d   = s1_d > s2_d ? 2'b01 : s2_d > s1_d ? 2'b10 : 2'b11;
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        game_start_d = state_d == LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tgt_q        <= 2'd0;
            cfg_q        <= 4'd0;
            m1_q         <= 2'd0;
            m2_q         <= 2'd0;
            res_q        <= 2'd0;
            s1_q         <= 2'd0;
            s2_q         <= 2'd0;
            gp_q         <= 4'd0;
            win_q        <= 2'd0;
            tmo_q        <= 4'd0;
            game_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cfg_q        <= cfg_d;
            m1_q         <= m1_d;
            m2_q         <= m2_d;
            res_q        <= res_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            gp_q         <= gp_d;
            win_q        <= win_d;
            tmo_q        <= tmo_d;
            game_start_q <= game_start_d;
        end
    end
endmodule

// File: tb/tb_match_scheduler.sv
// tb_match_scheduler: table-driven and randomized checks of match_scheduler against a
// result-history score model.
module tb_match_scheduler;
    localparam int MAXG = 3;
    localparam int TMO  = 4;

    logic       clk = 1'b0, rst_n = 1'b0, match_start = 1'b0;
    logic [1:0] target_wins = 2'd0;
    logic [3:0] rounds_cfg = 4'd0;
    logic [1:0] p1_move = 2'd0, p2_move = 2'd0;
    logic       p1_valid = 1'b0, p2_valid = 1'b0;
    logic [1:0] game_round = 2'd0, game_result = 2'd0;
    logic       p1_ready, p2_ready, game_start, match_done, busy;
    logic [1:0] game_p1, game_p2, score1, score2, match_winner;
    logic [3:0] games_played;

    match_scheduler #(.MAX_GAMES(MAXG), .RES_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .match_start(match_start), .target_wins(target_wins),
        .rounds_cfg(rounds_cfg), .p1_move(p1_move), .p2_move(p2_move), .p1_valid(p1_valid),
        .p2_valid(p2_valid), .p1_ready(p1_ready), .p2_ready(p2_ready), .game_start(game_start),
        .game_p1(game_p1), .game_p2(game_p2), .game_round(game_round), .game_result(game_result),
        .score1(score1), .score2(score2), .games_played(games_played), .match_winner(match_winner),
        .match_done(match_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] tw;
        logic [5:0] res;
        int         s1, s2, gp, win;
    } vec_t;

    int         npass = 0, ntot = 0;
    int         e_tw;
    logic [3:0] cur_rc;
    logic [1:0] hist[$];

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // scores are recounted from the full list of game results of the current match
    function automatic void model(output int s1, output int s2, output int gp, output int win,
                                  output bit over);
        s1 = 0;
        s2 = 0;
        foreach (hist[i]) begin
            if (hist[i] == 2'b01) s1++;
            if (hist[i] == 2'b10) s2++;
        end
        gp   = hist.size();
        over = s1 == e_tw || s2 == e_tw || gp == MAXG;
        win  = s1 > s2 ? 1 : s2 > s1 ? 2 : 3;
    endfunction

    task automatic chk_scores(input string nm);
        int s1, s2, gp, win;
        bit over;
        model(s1, s2, gp, win, over);
        chk({nm, "_s1"}, score1, s1);
        chk({nm, "_s2"}, score2, s2);
        chk({nm, "_gp"}, games_played, gp);
    endtask

    task automatic start_match(input logic [1:0] tw, input logic [3:0] rc);
        @(negedge clk);
        match_start = 1'b1;
        target_wins = tw;
        rounds_cfg  = rc;
        @(negedge clk);
        match_start = 1'b0;
        target_wins = 2'($urandom);
        rounds_cfg  = 4'($urandom);
        e_tw   = tw == 2'd0 ? 1 : int'(tw);
        cur_rc = rc;
        hist.delete();
        chk("load_start", game_start, 1);
        chk("load_cfg", {game_p1, game_p2}, rc);
        chk_scores("start");
    endtask

    // players begin legal offers after d1/d2 cycles; ill makes P1 offer 00 until then
    task automatic do_round(input logic [1:0] a, input logic [1:0] b, input int d1, input int d2,
                            input bit ill);
        int c = 0;
        bit g1 = 0, g2 = 0, a1 = 0, a2 = 0, ok = 1;
        while (!(g1 && g2) && c < 60) begin
            @(negedge clk);
            if (a1) begin g1 = 1; p1_valid = 1'b0; end
            if (a2) begin g2 = 1; p2_valid = 1'b0; end
            a1 = 0;
            a2 = 0;
            if (g1 && g2) break;
            if ({game_p1, game_p2} != 4'd0 || (c == 0 && game_start)) ok = 0;
            if ((g1 && p1_ready) || (g2 && p2_ready)) ok = 0;
            if (!g1) begin
                if (c >= d1) begin p1_valid = 1'b1; p1_move = a; a1 = p1_ready; end
                else if (ill) begin p1_valid = 1'b1; p1_move = 2'b00; if (!p1_ready) ok = 0; end
                else p1_valid = 1'b0;
            end
            if (!g2) begin
                if (c >= d2) begin p2_valid = 1'b1; p2_move = b; a2 = p2_ready; end
                else p2_valid = 1'b0;
            end
            c++;
        end
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        chk("collect_handshake", ok, 1);
        chk("collect_done", g1 && g2, 1);
        chk("issue_p1", game_p1, a);
        chk("issue_p2", game_p2, b);
    endtask

    task automatic wait_cycles(input int k);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (i == 1) chk("issue_len", {game_p1, game_p2}, 0);
        end
    endtask

    task automatic round_resp(input logic [1:0] r, input int k);
        wait_cycles(k);
        game_round = r;
        @(negedge clk);
        game_round = 2'b00;
        chk("round_back", p1_ready & p2_ready, 1);
        chk_scores("round");
    endtask

    task automatic timeout_resp();
        wait_cycles(TMO);
        chk("tmo_wait", {busy, p1_ready}, 2);
        @(negedge clk);
        chk("tmo_back", p1_ready & p2_ready, 1);
        chk_scores("tmo");
    endtask

    task automatic result_resp(input logic [1:0] r, input int k, output bit over);
        int s1, s2, gp, win;
        wait_cycles(k);
        game_result = r;
        @(negedge clk);
        game_result = 2'b00;
        hist.push_back(r);
        model(s1, s2, gp, win, over);
        @(negedge clk);
        chk("end_done", match_done, int'(over));
        chk_scores("result");
        if (over) begin
            chk("winner", match_winner, win);
            @(negedge clk);
            chk("idle_busy", {busy, match_done}, 0);
            chk("winner_hold", match_winner, win);
        end else begin
            chk("next_start", game_start, 1);
            chk("next_cfg", {game_p1, game_p2}, cur_rc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        bit   over;
        int   g;
        tbl[0] = '{tw: 2'd2, res: 6'b000101, s1: 2, s2: 0, gp: 2, win: 1};
        tbl[1] = '{tw: 2'd2, res: 6'b100111, s1: 1, s2: 1, gp: 3, win: 3};
        tbl[2] = '{tw: 2'd0, res: 6'b000010, s1: 0, s2: 1, gp: 1, win: 2};
        tbl[3] = '{tw: 2'd3, res: 6'b011001, s1: 2, s2: 1, gp: 3, win: 1};
        tbl[4] = '{tw: 2'd1, res: 6'b111111, s1: 0, s2: 0, gp: 3, win: 3};
        tbl[5] = '{tw: 2'd2, res: 6'b101110, s1: 0, s2: 2, gp: 3, win: 2};

        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, game_start, match_done, p1_ready, p2_ready, score1, score2,
                           games_played, match_winner, game_p1, game_p2}, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            start_match(tbl[i].tw, 4'(i + 1));
            over = 0;
            g = 0;
            while (!over && g < 3) begin
                do_round(2'b01, 2'b10, 0, 0, 0);
                result_resp(tbl[i].res[2*g +: 2], 1, over);
                g++;
            end
            chk("tbl_games", g, tbl[i].gp);
            chk("tbl_s1", score1, tbl[i].s1);
            chk("tbl_s2", score2, tbl[i].s2);
            chk("tbl_gp", games_played, tbl[i].gp);
            chk("tbl_win", match_winner, tbl[i].win);
        end

        // P2 early, P1 late; illegal P1 offers; silent game; then a win ends the match
        start_match(2'd2, 4'h9);
        do_round(2'b01, 2'b10, 3, 0, 0);
        round_resp(2'b01, 2);
        do_round(2'b11, 2'b01, 5, 0, 1);
        timeout_resp();
        do_round(2'b01, 2'b01, 0, 2, 0);
        result_resp(2'b01, TMO, over);
        do_round(2'b10, 2'b11, 1, 1, 0);
        result_resp(2'b01, 1, over);
        chk("seq_over", over, 1);

        // asynchronous reset mid-match, asserted between clock edges during LOAD
        start_match(2'd3, 4'h5);
        do_round(2'b01, 2'b10, 0, 0, 0);
        result_resp(2'b01, 1, over);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {busy, game_start, score1, score2, games_played, game_p1, game_p2}, 0);
        @(negedge clk);
        chk("rst_hold", {busy, game_start, p1_ready, match_done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", {busy, game_p1, game_p2, score1}, 0);

        repeat (25) begin
            start_match(2'($urandom_range(0, 3)), 4'($urandom));
            over = 0;
            g = 0;
            while (!over && g < MAXG) begin
                for (int j = 0; !over; j++) begin
                    int kind;
                    kind = j >= 3 ? 2 : $urandom_range(0, 2);
                    do_round(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
                             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                    if (kind == 0) round_resp(2'($urandom_range(1, 3)), $urandom_range(1, TMO));
                    else if (kind == 1) timeout_resp();
                    else begin
                        result_resp(2'($urandom_range(1, 3)), $urandom_range(1, TMO), over);
                        break;
                    end
                end
                g++;
            end
            chk("rand_over", over, 1);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
